// File: rtl/pmips_pkg.sv
`default_nettype none
// ============================================================================
// Module : pmips_pkg
// Brief  : Shared PMIPS constants: NOP encoding, opcodes, instruction field
//          slices and the pipe-sequencer state type.
// Rev    : 1.0  initial release
// ============================================================================
package pmips_pkg;

  // Bubble / NOP encoding used in every pipeline stage
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Opcodes held in the OP field
  localparam logic [2:0] RTYPE = 3'd0;
  localparam logic [2:0] BEQ   = 3'd2;
  localparam logic [2:0] ADDI  = 3'd3;
  localparam logic [2:0] LW    = 3'd5;
  localparam logic [2:0] SW    = 3'd6;

  // Instruction field bit positions
  localparam int OP_HI = 15;
  localparam int OP_LO = 13;
  localparam int RS_HI = 12;
  localparam int RS_LO = 10;
  localparam int RT_HI = 9;
  localparam int RT_LO = 7;
  localparam int RD_HI = 6;
  localparam int RD_LO = 4;

  // Front-end sequencing states
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } seq_state_t;

  // Extract the opcode of an instruction word
  function automatic logic [2:0] instr_op(input logic [15:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmips_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : pmips_sat_counter
// Brief  : Enabled up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
module pmips_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles, holding once the maximum value is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != c_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pmips_pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pmips_pipe_sequencer
// Brief  : Owns the PC and the instruction-tracking pipeline registers.
//          Holds the front end and injects bubbles on stall, redirects and
//          squashes on a taken branch, and keeps stall/flush statistics plus
//          a sticky stall watchdog.
// Rev    : 1.0  initial release
// ============================================================================
module pmips_pipe_sequencer
  import pmips_pkg::*;
#(
  parameter logic [15:0] PC_RESET  = 16'h0000,
  parameter logic [15:0] PC_STEP   = 16'd2,
  parameter int          MAX_STALL = 3,
  parameter int          CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic [15:0]      branch_target,
  input  logic [15:0]      imem_instr,
  output logic [15:0]      pc,
  output logic [15:0]      ifid,
  output logic [15:0]      ifid_pc,
  output logic [15:0]      idex,
  output logic [15:0]      exmem,
  output logic [15:0]      memwb,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_timeout
);

  // Consecutive-stall length at which the watchdog trips; the run counter
  // saturates there so long stalls cannot wrap it back below the limit.
  localparam logic [7:0] c_RUN_LIMIT = 8'(MAX_STALL + 1);

  seq_state_t  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ifid;
  logic [15:0] r_ifid_pc;
  logic [15:0] r_idex;
  logic [15:0] r_exmem;
  logic [15:0] r_memwb;
  logic [7:0]  r_stall_run;
  logic        r_timeout;

  logic        w_branch;
  logic        w_stall;
  logic [7:0]  w_stall_run_nxt;
  logic [15:0] w_pc_inc;

  // Decode this cycle's action: branch beats stall, and the fill cycle
  // after reset never stalls
  always_comb begin
    w_branch        = branch_taken;
    w_stall         = stall_req && !branch_taken && (r_state != S_FILL);
    w_pc_inc        = r_pc + PC_STEP;
    w_stall_run_nxt = 8'd0;
    if (w_stall) begin
      if (r_state == S_RUN) begin
        w_stall_run_nxt = 8'd1;
      end else if (r_stall_run != c_RUN_LIMIT) begin
        w_stall_run_nxt = r_stall_run + 8'd1;
      end else begin
        w_stall_run_nxt = r_stall_run;
      end
    end
  end

  // Sequencer FSM: PC, front-end registers, free-running back end, watchdog
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_FILL;
      r_pc        <= PC_RESET;
      r_ifid      <= NOP_INSTR;
      r_ifid_pc   <= 16'h0000;
      r_idex      <= NOP_INSTR;
      r_exmem     <= NOP_INSTR;
      r_memwb     <= NOP_INSTR;
      r_stall_run <= 8'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_exmem     <= r_idex;
      r_memwb     <= r_exmem;
      r_stall_run <= w_stall_run_nxt;
      if (w_stall_run_nxt == c_RUN_LIMIT) begin
        r_timeout <= 1'b1;
      end

      if (w_branch) begin
        // Redirect and squash the two wrong-path instructions
        r_pc    <= branch_target;
        r_ifid  <= NOP_INSTR;
        r_idex  <= NOP_INSTR;
        r_state <= S_RUN;
      end else begin
        case (r_state)
          S_FILL: begin
            r_pc      <= w_pc_inc;
            r_ifid    <= imem_instr;
            r_ifid_pc <= r_pc;
            r_idex    <= NOP_INSTR;
            r_state   <= S_RUN;
          end
          default: begin
            if (w_stall) begin
              r_idex  <= NOP_INSTR;
              r_state <= S_STALL;
            end else begin
              r_pc      <= w_pc_inc;
              r_ifid    <= imem_instr;
              r_ifid_pc <= r_pc;
              r_idex    <= r_ifid;
              r_state   <= S_RUN;
            end
          end
        endcase
      end
    end
  end

  pmips_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_en    (w_stall),
    .o_count (stall_count)
  );

  pmips_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_en    (w_branch),
    .o_count (flush_count)
  );

  assign pc            = r_pc;
  assign ifid          = r_ifid;
  assign ifid_pc       = r_ifid_pc;
  assign idex          = r_idex;
  assign exmem         = r_exmem;
  assign memwb         = r_memwb;
  assign stall_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pmips_pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_pmips_pipe_sequencer
// Brief  : Self-checking bench for pmips_pipe_sequencer: directed scenarios
//          plus randomized stall/branch traffic against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pmips_pipe_sequencer;

  localparam int MAX_STALL = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] imem_instr;
  logic [15:0] pc, ifid, ifid_pc, idex, exmem, memwb;
  logic [15:0] stall_count, flush_count;
  logic        stall_timeout;

  int n_pass = 0;
  int n_total = 0;

  // Instruction memory: 0 = single program word at 0, 1 = constant, 2 = hash
  int          imem_mode = 0;
  logic [15:0] imem_const = 16'h0000;

  assign imem_instr = (imem_mode == 0) ? ((pc == 16'h0000) ? 16'h6A81 : 16'h0000) :
                      (imem_mode == 1) ? imem_const :
                      {pc[7:0] ^ 8'h5A, pc[15:8] ^ 8'hC3};

  pmips_pipe_sequencer #(
    .PC_RESET  (16'h0000),
    .PC_STEP   (16'd2),
    .MAX_STALL (MAX_STALL),
    .CNT_W     (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_instr    (imem_instr),
    .pc            (pc),
    .ifid          (ifid),
    .ifid_pc       (ifid_pc),
    .idex          (idex),
    .exmem         (exmem),
    .memwb         (memwb),
    .stall_count   (stall_count),
    .flush_count   (flush_count),
    .stall_timeout (stall_timeout)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural reference model ----------------
  logic [15:0] m_pc, m_ifid, m_ifid_pc, m_idex, m_exmem, m_memwb;
  bit          m_ifid_pc_known;
  bit          m_first;
  int          m_run, m_stalls, m_flushes;
  bit          m_to;

  function automatic logic [15:0] imem_model(input logic [15:0] a);
    if (imem_mode == 0) return (a == 16'h0000) ? 16'h6A81 : 16'h0000;
    if (imem_mode == 1) return imem_const;
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_ifid = 16'h0000; m_ifid_pc = 16'h0000; m_idex = 16'h0000;
    m_exmem = 16'h0000; m_memwb = 16'h0000; m_ifid_pc_known = 1'b1;
    m_first = 1'b1; m_run = 0; m_stalls = 0; m_flushes = 0; m_to = 1'b0;
  endtask

  // One clock edge of architectural behaviour
  task automatic model_edge(input bit st, input bit br, input logic [15:0] tgt);
    logic [15:0] fetched;
    fetched = imem_model(m_pc);
    m_memwb = m_exmem;
    m_exmem = m_idex;
    if (br) begin
      m_pc = tgt; m_ifid = 16'h0000; m_idex = 16'h0000; m_ifid_pc_known = 1'b0;
      if (m_flushes < 65535) m_flushes++;
      m_run = 0; m_first = 1'b0;
    end else if (m_first || !st) begin
      m_idex = m_first ? 16'h0000 : m_ifid;
      m_ifid = fetched; m_ifid_pc = m_pc; m_ifid_pc_known = 1'b1;
      m_pc = m_pc + 16'd2; m_first = 1'b0; m_run = 0;
    end else begin
      m_idex = 16'h0000;
      if (m_stalls < 65535) m_stalls++;
      m_run++;
    end
    if (m_run > MAX_STALL) m_to = 1'b1;
  endtask

  // Drive inputs, advance model and DUT by one edge, land 1ns after the edge
  task automatic tick(input bit st, input bit br, input logic [15:0] tgt);
    stall_req = st; branch_taken = br; branch_target = tgt;
    model_edge(st, br, tgt);
    @(posedge clock);
    #1;
  endtask

  // Pulse reset between edges (called 1ns after an edge)
  task automatic apply_reset();
    stall_req = 1'b0; branch_taken = 1'b0;
    #3 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_total++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h expected 0000", pc); else n_pass++;
    n_total++; if ({ifid, ifid_pc, idex, exmem, memwb} !== 80'h0) $display("FAIL reset_stages: got %h expected 0", {ifid, ifid_pc, idex, exmem, memwb}); else n_pass++;
    n_total++; if ({stall_count, flush_count, stall_timeout} !== 33'h0) $display("FAIL reset_stats: got %h expected 0", {stall_count, flush_count, stall_timeout}); else n_pass++;
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_fill_free_run();
    imem_mode = 0;
    apply_reset();
    tick(0, 0, 16'h0);
    n_total++; if (pc !== 16'h0002) $display("FAIL fill_pc: got %h expected 0002", pc); else n_pass++;
    n_total++; if (ifid !== 16'h6A81) $display("FAIL fill_ifid: got %h expected 6A81", ifid); else n_pass++;
    n_total++; if (idex !== 16'h0000) $display("FAIL fill_idex: got %h expected 0000", idex); else n_pass++;
    tick(0, 0, 16'h0);
    n_total++; if (idex !== 16'h6A81) $display("FAIL run_idex: got %h expected 6A81", idex); else n_pass++;
    n_total++; if (pc !== 16'h0004) $display("FAIL run_pc: got %h expected 0004", pc); else n_pass++;
    tick(0, 0, 16'h0);
    n_total++; if (exmem !== 16'h6A81) $display("FAIL run_exmem: got %h expected 6A81", exmem); else n_pass++;
    tick(0, 0, 16'h0);
    n_total++; if (memwb !== 16'h6A81) $display("FAIL run_memwb: got %h expected 6A81", memwb); else n_pass++;
  endtask

  task automatic test_stall();
    imem_mode = 1; imem_const = 16'h0A90;
    apply_reset();
    tick(0, 0, 16'h0);
    imem_const = 16'h1234;
    for (int k = 1; k <= 2; k++) begin
      tick(1, 0, 16'h0);
      n_total++; if (pc !== 16'h0002) $display("FAIL stall_pc_hold: got %h expected 0002", pc); else n_pass++;
      n_total++; if (ifid !== 16'h0A90) $display("FAIL stall_ifid_hold: got %h expected 0A90", ifid); else n_pass++;
      n_total++; if (idex !== 16'h0000) $display("FAIL stall_bubble: got %h expected 0000", idex); else n_pass++;
      n_total++; if (stall_count !== 16'(k)) $display("FAIL stall_count: got %0d expected %0d", stall_count, k); else n_pass++;
    end
    tick(0, 0, 16'h0);
    n_total++; if (idex !== 16'h0A90) $display("FAIL stall_release_idex: got %h expected 0A90", idex); else n_pass++;
    n_total++; if (ifid !== 16'h1234) $display("FAIL stall_release_ifid: got %h expected 1234", ifid); else n_pass++;
    n_total++; if (ifid_pc !== 16'h0002) $display("FAIL stall_release_ifid_pc: got %h expected 0002", ifid_pc); else n_pass++;
    n_total++; if (stall_count !== 16'd2) $display("FAIL stall_count_after: got %0d expected 2", stall_count); else n_pass++;
  endtask

  task automatic test_branch_over_stall();
    imem_mode = 2;
    apply_reset();
    tick(0, 0, 16'h0);
    tick(0, 0, 16'h0);
    tick(1, 0, 16'h0);
    tick(1, 1, 16'h0040);
    n_total++; if (pc !== 16'h0040) $display("FAIL br_pc: got %h expected 0040", pc); else n_pass++;
    n_total++; if ({ifid, idex} !== 32'h0) $display("FAIL br_squash: got %h expected 0", {ifid, idex}); else n_pass++;
    n_total++; if (flush_count !== 16'd1) $display("FAIL br_flush_count: got %0d expected 1", flush_count); else n_pass++;
    n_total++; if (stall_count !== 16'd1) $display("FAIL br_stall_count: got %0d expected 1", stall_count); else n_pass++;
    tick(0, 0, 16'h0);
    n_total++; if (ifid !== imem_model(16'h0040)) $display("FAIL br_refetch: got %h expected %h", ifid, imem_model(16'h0040)); else n_pass++;
    n_total++; if (pc !== 16'h0042) $display("FAIL br_next_pc: got %h expected 0042", pc); else n_pass++;
  endtask

  task automatic test_watchdog();
    imem_mode = 2;
    apply_reset();
    tick(0, 0, 16'h0);
    tick(0, 0, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      tick(1, 0, 16'h0);
      n_total++; if (stall_timeout !== (k == 4)) $display("FAIL wdog_edge%0d: got %b expected %b", k, stall_timeout, (k == 4)); else n_pass++;
    end
    tick(0, 0, 16'h0);
    tick(0, 0, 16'h0);
    n_total++; if (stall_timeout !== 1'b1) $display("FAIL wdog_sticky: got %b expected 1", stall_timeout); else n_pass++;
    n_total++; if (stall_count !== 16'd4) $display("FAIL wdog_stall_count: got %0d expected 4", stall_count); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    imem_mode = 2;
    apply_reset();
    tick(0, 0, 16'h0);
    tick(0, 1, 16'hFFFE);
    n_total++; if (pc !== 16'hFFFE) $display("FAIL wrap_target: got %h expected FFFE", pc); else n_pass++;
    tick(0, 0, 16'h0);
    n_total++; if (pc !== 16'h0000) $display("FAIL wrap_pc: got %h expected 0000", pc); else n_pass++;
    n_total++; if (ifid_pc !== 16'hFFFE) $display("FAIL wrap_ifid_pc: got %h expected FFFE", ifid_pc); else n_pass++;
  endtask

  task automatic test_async_reset();
    imem_mode = 0;
    apply_reset();
    tick(0, 0, 16'h0);
    tick(0, 0, 16'h0);
    tick(1, 0, 16'h0);
    tick(1, 0, 16'h0);
    #2 reset = 1'b1;
    #1;
    n_total++; if (pc !== 16'h0000) $display("FAIL areset_pc: got %h expected 0000", pc); else n_pass++;
    n_total++; if ({ifid, ifid_pc, idex, exmem, memwb} !== 80'h0) $display("FAIL areset_stages: got %h expected 0", {ifid, ifid_pc, idex, exmem, memwb}); else n_pass++;
    n_total++; if ({stall_count, stall_timeout} !== 17'h0) $display("FAIL areset_stats: got %h expected 0", {stall_count, stall_timeout}); else n_pass++;
    #2 reset = 1'b0;
    model_reset();
    tick(1, 0, 16'h0);
    n_total++; if (pc !== 16'h0002) $display("FAIL areset_fill_pc: got %h expected 0002", pc); else n_pass++;
    n_total++; if (ifid !== 16'h6A81) $display("FAIL areset_fill_ifid: got %h expected 6A81", ifid); else n_pass++;
    n_total++; if (stall_count !== 16'd0) $display("FAIL areset_fill_nostall: got %0d expected 0", stall_count); else n_pass++;
    tick(1, 0, 16'h0);
    n_total++; if (pc !== 16'h0002) $display("FAIL areset_then_stall_pc: got %h expected 0002", pc); else n_pass++;
    n_total++; if (stall_count !== 16'd1) $display("FAIL areset_then_stall_cnt: got %0d expected 1", stall_count); else n_pass++;
  endtask

  task automatic test_random();
    int          burst;
    bit          st, br;
    logic [15:0] tgt;
    imem_mode = 2;
    burst = 0;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (burst > 0) begin
        st = 1'b1; burst--;
      end else if ($urandom_range(99) < 8) begin
        st = 1'b1; burst = int'($urandom_range(6));
      end else begin
        st = ($urandom_range(99) < 25);
      end
      br  = ($urandom_range(99) < 7);
      tgt = 16'($urandom) & 16'hFFFE;
      tick(st, br, tgt);
      n_total++; if (pc !== m_pc) $display("FAIL rnd_pc cyc%0d: got %h expected %h", cyc, pc, m_pc); else n_pass++;
      n_total++; if ({ifid, idex} !== {m_ifid, m_idex}) $display("FAIL rnd_front cyc%0d: got %h expected %h", cyc, {ifid, idex}, {m_ifid, m_idex}); else n_pass++;
      n_total++; if ({exmem, memwb} !== {m_exmem, m_memwb}) $display("FAIL rnd_back cyc%0d: got %h expected %h", cyc, {exmem, memwb}, {m_exmem, m_memwb}); else n_pass++;
      if (m_ifid_pc_known) begin
        n_total++; if (ifid_pc !== m_ifid_pc) $display("FAIL rnd_ifid_pc cyc%0d: got %h expected %h", cyc, ifid_pc, m_ifid_pc); else n_pass++;
      end
      n_total++; if (stall_count !== 16'(m_stalls)) $display("FAIL rnd_stall_count cyc%0d: got %0d expected %0d", cyc, stall_count, m_stalls); else n_pass++;
      n_total++; if (flush_count !== 16'(m_flushes)) $display("FAIL rnd_flush_count cyc%0d: got %0d expected %0d", cyc, flush_count, m_flushes); else n_pass++;
      n_total++; if (stall_timeout !== m_to) $display("FAIL rnd_timeout cyc%0d: got %b expected %b", cyc, stall_timeout, m_to); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    @(posedge clock);
    #1;
    test_fill_free_run();
    test_stall();
    test_branch_over_stall();
    test_watchdog();
    test_pc_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pmips_pipe_sequencer.md
Name: pmips_pipe_sequencer

Overview:
- Feeds the PMIPS hazard-detection controller. The controller reads the instruction words in IF/ID, ID/EX and EX/MEM and returns a stall level; this block receives that stall and drives those instruction words.
- Owns the PC and the instruction-tracking pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- On a stall it holds the PC and IF/ID and inserts a bubble (16'h0000) into ID/EX. On a taken branch it redirects the PC and squashes wrong-path instructions.
- Provides stall and flush statistics and a stall-watchdog error.

Parameters:
- PC_RESET, 16'h0000, PC value loaded at reset.
- PC_STEP, 2, PC increment per fetch (byte-addressed 16-bit instructions).
- MAX_STALL, 3, maximum legal consecutive stall cycles before the watchdog fires.
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall_req  in  1  stall level from the hazard controller (1 = hold); sampled at posedge.
- branch_taken  in  1  beq resolved taken in EX/MEM stage.
- branch_target  in  16  redirect address, valid when branch_taken = 1.
- imem_instr  in  16  instruction memory read data for address pc (combinational).
- pc  out  16  fetch address to instruction memory.
- ifid  out  16  IF/ID instruction word.
- ifid_pc  out  16  PC of the instruction in IF/ID (used by branch target adder).
- idex  out  16  ID/EX instruction word.
- exmem  out  16  EX/MEM instruction word.
- memwb  out  16  MEM/WB instruction word.
- stall_count  out  CNT_W  cycles spent in stall; saturating.
- flush_count  out  CNT_W  taken-branch redirects; saturating.
- stall_timeout  out  1  sticky error flag.

Behaviour:
- Reset values:
  - pc = PC_RESET.
  - ifid, ifid_pc, idex, exmem, memwb = 0.
  - Counters = 0, stall_timeout = 0, state = S_FILL.
- Bubble/NOP encoding is 16'h0000 in every stage.
- Shift rule: exmem <= idex and memwb <= exmem advance every cycle in all cases. The back end never stalls.
- States:
  - S_FILL: one cycle after reset release. pc <= pc + PC_STEP, ifid <= imem_instr, idex <= 0. stall_req is ignored. Then -> S_RUN.
  - S_RUN, normal case (no branch, no stall): pc <= pc + PC_STEP, ifid <= imem_instr, ifid_pc <= pc, idex <= ifid.
  - S_RUN, stall_req = 1 and branch_taken = 0: pc, ifid and ifid_pc hold; idex <= 0; stall_count += 1; stall_run <= 1; -> S_STALL.
  - S_STALL: same actions as the stall case while stall_req = 1, incrementing stall_run each cycle. When stall_req = 0 -> S_RUN with normal advance that same edge.
- Branch handling, any state: branch_taken = 1 has priority over stall_req.
  - pc <= branch_target, ifid <= 0, idex <= 0, flush_count += 1, stall_run <= 0, -> S_RUN.
  - Wrong-path ifid and idex are squashed. exmem <= idex still shifts; the branch itself moves to memwb.
- Watchdog: if stall_run reaches MAX_STALL + 1, stall_timeout <= 1 (sticky until reset). Sequencing continues unchanged.
- Arithmetic:
  - PC add is modulo 2^16; 16'hFFFE + 2 wraps to 16'h0000.
  - Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-branch: all outputs return to reset values asynchronously. The first edge after release is handled in S_FILL.
- Latency: imem_instr fetched at edge N appears on ifid after edge N and on idex after edge N+1, if no stall.

Decomposition:
- Shared package pmips_pkg:
  - NOP_INSTR = 16'h0000.
  - Opcode constants: RTYPE = 0, BEQ = 2, ADDI = 3, LW = 5, SW = 6.
  - Field slice constants: OP [15:13], RS [12:10], RT [9:7], RD [6:4].
  - seq_state_t enum: S_FILL, S_RUN, S_STALL.
- One sub-module, pmips_sat_counter (CNT_W-wide, enable, async reset, saturating), instantiated for stall_count and flush_count.

Test Plan:
- Reset then free-run, imem returns 16'h6A81 at pc 0 and 16'h0000 after -> after edge 1: pc = 2, ifid = 16'h6A81; after edge 2: idex = 16'h6A81; after edge 3: exmem = 16'h6A81.
- stall_req = 1 for 2 cycles with ifid = 16'h0A90 -> pc and ifid held, idex = 0 for both cycles, stall_count = 2, then ifid advances to idex.
- branch_taken = 1 with branch_target = 16'h0040 while stall_req = 1 -> pc = 16'h0040, ifid = 0, idex = 0, flush_count = 1, stall_count unchanged.
- stall_req held high for 4 cycles (MAX_STALL = 3) -> stall_timeout rises on the 4th edge and stays 1 after stall_req drops.
- PC wrap: branch to 16'hFFFE, then free-run one cycle -> pc = 16'h0000.
- Assert reset asynchronously mid-stall, between clock edges -> pc = 0 and all stage registers = 0 immediately, without waiting for an edge; first edge after release behaves as S_FILL.
